// File: rtl/pa_fdsu_srt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pa_fdsu_srt_ctrl
// Purpose  : Sequencing controller for the FDSU divide/sqrt unit. Takes an
//            issued op plus the EX1 special-case results. It runs the radix-4
//            SRT iterations and a single round cycle, and it presents the
//            result to writeback through a valid/ready handshake.
// Options  : PA_FDSU_EARLY_TERM_EN - leave SRT early when the partial
//            remainder becomes zero.
// Revision : 1.0 - initial release
// ============================================================================
module pa_fdsu_srt_ctrl #(
  parameter int SRT_ITER = 13,
  parameter int CNT_W    = 4
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             fdsu_ex1_start,
  input  logic             ex1_div,
  input  logic             ex1_sqrt,
  input  logic             ex1_srt_skip,
  input  logic [7:0]       fdsu_fpu_ex1_special_sel,
  input  logic [3:0]       fdsu_fpu_ex1_special_sign,
  input  logic [4:0]       fdsu_fpu_ex1_fflags,
  input  logic             srt_rem_zero,
  input  logic [4:0]       rnd_fflags,
  input  logic             fpu_fdsu_flush,
  input  logic             fpu_fdsu_wb_ready,
  output logic             fdsu_busy,
  output logic             srt_first,
  output logic             srt_iter_en,
  output logic [CNT_W-1:0] srt_cnt,
  output logic             rnd_en,
  output logic             fdsu_wb_vld,
  output logic             fdsu_wb_special,
  output logic [7:0]       fdsu_wb_special_sel,
  output logic [3:0]       fdsu_wb_special_sign,
  output logic [4:0]       fdsu_wb_fflags,
  output logic             fdsu_wb_op_sqrt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SRT  = 2'd1;
  localparam logic [1:0] ST_RND  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(SRT_ITER - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_srt_first;
  logic             r_skip;
  logic             r_sqrt;
  logic [7:0]       r_sel;
  logic [3:0]       r_sign;
  logic [4:0]       r_fflags;
  logic             w_accept;
  logic             w_early_term;

  // A start counts only from IDLE. It must not be flushed and must name a real operation.
  assign w_accept = (r_state == ST_IDLE) & fdsu_ex1_start & ~fpu_fdsu_flush
                  & (ex1_div | ex1_sqrt);

`ifdef PA_FDSU_EARLY_TERM_EN
  // A zero remainder is meaningless on the first cycle, before it is initialised.
  assign w_early_term = srt_rem_zero & ~r_srt_first;
`else
  // The port stays for interface compatibility, but it never terminates early.
  assign w_early_term = srt_rem_zero & 1'b0;
`endif

  // Next-state selection; flush overrides every other exit, including the handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ex1_srt_skip ? ST_WB : ST_SRT;
      ST_SRT: begin
        if (fpu_fdsu_flush)                         w_state_nxt = ST_IDLE;
        else if ((r_cnt == '0) || w_early_term)     w_state_nxt = ST_RND;
      end
      ST_RND:  w_state_nxt = fpu_fdsu_flush ? ST_IDLE : ST_WB;
      ST_WB:   if (fpu_fdsu_flush || fpu_fdsu_wb_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Remaining-iteration counter; it saturates at zero and does not wrap.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= ex1_srt_skip ? '0 : C_CNT_INIT;
    end else if ((r_state == ST_SRT) && !fpu_fdsu_flush) begin
      if (w_early_term)     r_cnt <= '0;
      else if (r_cnt != '0) r_cnt <= r_cnt - C_CNT_ONE;
    end
  end

  // First-iteration marker: high only in the cycle after a non-skip accept.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) r_srt_first <= 1'b0;
    else           r_srt_first <= w_accept & ~ex1_srt_skip;
  end

  // Operation fields are captured at accept. Round flags are merged in during the round cycle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_skip   <= 1'b0;
      r_sqrt   <= 1'b0;
      r_sel    <= '0;
      r_sign   <= '0;
      r_fflags <= '0;
    end else if (w_accept) begin
      r_skip   <= ex1_srt_skip;
      r_sqrt   <= ex1_sqrt;
      r_sel    <= fdsu_fpu_ex1_special_sel;
      r_sign   <= fdsu_fpu_ex1_special_sign;
      r_fflags <= fdsu_fpu_ex1_fflags;
    end else if ((r_state == ST_RND) && !fpu_fdsu_flush) begin
      r_fflags <= r_fflags | rnd_fflags;
    end
  end

  assign fdsu_busy            = (r_state != ST_IDLE);
  assign srt_iter_en          = (r_state == ST_SRT);
  assign srt_first            = r_srt_first;
  assign srt_cnt              = r_cnt;
  assign rnd_en               = (r_state == ST_RND);
  assign fdsu_wb_vld          = (r_state == ST_WB);
  assign fdsu_wb_special      = r_skip;
  assign fdsu_wb_special_sel  = r_sel;
  assign fdsu_wb_special_sign = r_sign;
  assign fdsu_wb_fflags       = r_fflags;
  assign fdsu_wb_op_sqrt      = r_sqrt;

endmodule
`default_nettype wire

// File: tb/tb_pa_fdsu_srt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pa_fdsu_srt_ctrl
// Purpose  : Self-checking bench for pa_fdsu_srt_ctrl. It uses directed
//            scenarios and random traffic, and checks against a model that
//            counts elapsed cycles since accept.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pa_fdsu_srt_ctrl;
  localparam int SRT_ITER = 13;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             cpurst_b = 1'b0;
  logic             fdsu_ex1_start = 0, ex1_div = 0, ex1_sqrt = 0, ex1_srt_skip = 0;
  logic [7:0]       sel_in = '0;
  logic [3:0]       sign_in = '0;
  logic [4:0]       ff_in = '0, rnd_fflags = '0;
  logic             srt_rem_zero = 0, fpu_fdsu_flush = 0, fpu_fdsu_wb_ready = 0;
  logic             fdsu_busy, srt_first, srt_iter_en, rnd_en, fdsu_wb_vld;
  logic             fdsu_wb_special, fdsu_wb_op_sqrt;
  logic [CNT_W-1:0] srt_cnt;
  logic [7:0]       fdsu_wb_special_sel;
  logic [3:0]       fdsu_wb_special_sign;
  logic [4:0]       fdsu_wb_fflags;

  pa_fdsu_srt_ctrl #(.SRT_ITER(SRT_ITER), .CNT_W(CNT_W)) dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b),
    .fdsu_ex1_start(fdsu_ex1_start), .ex1_div(ex1_div), .ex1_sqrt(ex1_sqrt),
    .ex1_srt_skip(ex1_srt_skip), .fdsu_fpu_ex1_special_sel(sel_in),
    .fdsu_fpu_ex1_special_sign(sign_in), .fdsu_fpu_ex1_fflags(ff_in),
    .srt_rem_zero(srt_rem_zero), .rnd_fflags(rnd_fflags),
    .fpu_fdsu_flush(fpu_fdsu_flush), .fpu_fdsu_wb_ready(fpu_fdsu_wb_ready),
    .fdsu_busy(fdsu_busy), .srt_first(srt_first), .srt_iter_en(srt_iter_en),
    .srt_cnt(srt_cnt), .rnd_en(rnd_en), .fdsu_wb_vld(fdsu_wb_vld),
    .fdsu_wb_special(fdsu_wb_special), .fdsu_wb_special_sel(fdsu_wb_special_sel),
    .fdsu_wb_special_sign(fdsu_wb_special_sign), .fdsu_wb_fflags(fdsu_wb_fflags),
    .fdsu_wb_op_sqrt(fdsu_wb_op_sqrt)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0, ncyc = 0;

  // Transaction model: an active op, the cycles elapsed since accept, and how many SRT cycles it uses.
  bit       m_active = 0, m_skip = 0, m_sqrt = 0;
  int       m_k = 0, m_end = SRT_ITER;
  bit [7:0] m_sel = '0;
  bit [3:0] m_sign = '0;
  bit [4:0] m_ff = '0;

  // Directed-scenario observations
  int vld_first, rnd_first, first_cyc, n_iter, n_vld, cap_ff, cap_sel, cap_special;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, ncyc, act, exp);
    end
  endfunction

  // 0 idle, 1 iterating, 2 rounding, 3 writeback, derived from the elapsed count.
  function automatic int model_phase();
    if (!m_active)               return 0;
    if (m_skip)                  return 3;
    if (m_k <= m_end)            return 1;
    if (m_k == m_end + 1)        return 2;
    return 3;
  endfunction

  function automatic void model_advance();
    int ph = model_phase();
    if (!m_active) begin
      if (fdsu_ex1_start && !fpu_fdsu_flush && (ex1_div || ex1_sqrt)) begin
        m_active = 1; m_k = 1; m_end = SRT_ITER;
        m_skip = ex1_srt_skip; m_sqrt = ex1_sqrt;
        m_sel = sel_in; m_sign = sign_in; m_ff = ff_in;
      end
    end else if (fpu_fdsu_flush) begin
      m_active = 0;
    end else begin
`ifdef PA_FDSU_EARLY_TERM_EN
      if (ph == 1 && srt_rem_zero && m_k >= 2) m_end = m_k;
`endif
      if (ph == 2) m_ff = m_ff | rnd_fflags;
      if (ph == 3 && fpu_fdsu_wb_ready) m_active = 0;
      m_k++;
    end
  endfunction

  task automatic check();
    int ph = model_phase();
    chk("busy",      int'(fdsu_busy),   int'(m_active));
    chk("iter_en",   int'(srt_iter_en), int'(ph == 1));
    chk("srt_first", int'(srt_first),   int'(ph == 1 && m_k == 1));
    chk("rnd_en",    int'(rnd_en),      int'(ph == 2));
    chk("wb_vld",    int'(fdsu_wb_vld), int'(ph == 3));
    if (ph == 1) chk("srt_cnt", int'(srt_cnt), SRT_ITER - m_k);
    if (ph == 3) begin
      chk("wb_special", int'(fdsu_wb_special),      int'(m_skip));
      chk("wb_sel",     int'(fdsu_wb_special_sel),  int'(m_sel));
      chk("wb_sign",    int'(fdsu_wb_special_sign), int'(m_sign));
      chk("wb_fflags",  int'(fdsu_wb_fflags),       int'(m_ff));
      chk("wb_sqrt",    int'(fdsu_wb_op_sqrt),      int'(m_sqrt));
    end
    if (srt_iter_en) n_iter++;
    if (fdsu_wb_vld) n_vld++;
    if (srt_first && first_cyc < 0) first_cyc = ncyc;
    if (rnd_en && rnd_first < 0) rnd_first = ncyc;
    if (fdsu_wb_vld && vld_first < 0) begin
      vld_first = ncyc; cap_ff = int'(fdsu_wb_fflags);
      cap_sel = int'(fdsu_wb_special_sel); cap_special = int'(fdsu_wb_special);
    end
  endtask

  task automatic tick();
    model_advance();
    @(negedge clk);
    ncyc++;
    check();
  endtask

  task automatic clr_stats();
    vld_first = -1; rnd_first = -1; first_cyc = -1;
    n_iter = 0; n_vld = 0; cap_ff = -1; cap_sel = -1; cap_special = -1;
  endtask

  task automatic do_start(input bit skip, input bit sqrt, input logic [7:0] sel,
                          input logic [3:0] sign, input logic [4:0] ff);
    fdsu_ex1_start = 1; ex1_div = ~sqrt; ex1_sqrt = sqrt; ex1_srt_skip = skip;
    sel_in = sel; sign_in = sign; ff_in = ff;
    tick();
    fdsu_ex1_start = 0; ex1_div = 0; ex1_sqrt = 0; ex1_srt_skip = 0;
  endtask

  task automatic run_until_vld(input int budget);
    for (int i = 0; i < budget && vld_first < 0; i++) tick();
    if (vld_first < 0) begin
      n_checks++; n_err++;
      $display("FAIL vld_timeout at cycle %0d: got no wb_vld within %0d cycles", ncyc, budget);
    end
  endtask

  int T;

  initial begin
    clr_stats();
    repeat (2) @(negedge clk);
    // Reset state, hand-pinned
    chk("rst_busy", int'(fdsu_busy), 0);
    chk("rst_vld",  int'(fdsu_wb_vld), 0);
    chk("rst_cnt",  int'(srt_cnt), 0);
    chk("rst_ff",   int'(fdsu_wb_fflags), 0);
    chk("rst_sel",  int'(fdsu_wb_special_sel), 0);
    chk("rst_iter", int'(srt_iter_en | srt_first | rnd_en | fdsu_wb_special | fdsu_wb_op_sqrt), 0);
    cpurst_b = 1;

    // Normal divide with ready tied high; this also checks that round flags merge in
    fpu_fdsu_wb_ready = 1; rnd_fflags = 5'h01;
    clr_stats(); T = ncyc;
    do_start(0, 0, 8'h55, 4'h3, 5'h00);
    run_until_vld(40); repeat (2) tick();
    chk("t1_vld_lat",  vld_first - T, 15);
    chk("t1_first",    first_cyc - T, 1);
    chk("t1_iters",    n_iter, 13);
    chk("t1_rnd_lat",  rnd_first - T, 14);
    chk("t1_nvld",     n_vld, 1);
    chk("t1_fflags",   cap_ff, 5'h01);
    chk("t1_special",  cap_special, 0);

    // Special skip path: the round flags must not be merged
    clr_stats(); T = ncyc;
    do_start(1, 0, 8'h08, 4'h1, 5'h10);
    run_until_vld(10); repeat (2) tick();
    chk("t2_vld_lat", vld_first - T, 1);
    chk("t2_sel",     cap_sel, 8'h08);
    chk("t2_fflags",  cap_ff, 5'h10);
    chk("t2_iters",   n_iter, 0);
    chk("t2_special", cap_special, 1);

    // Backpressure: valid held for six cycles, and a start in the handshake cycle is ignored
    fpu_fdsu_wb_ready = 0; rnd_fflags = 5'h02;
    clr_stats();
    do_start(0, 1, 8'hA5, 4'h9, 5'h04);
    run_until_vld(40);
    repeat (5) tick();
    fpu_fdsu_wb_ready = 1; fdsu_ex1_start = 1; ex1_div = 1;
    tick();
    fdsu_ex1_start = 0; ex1_div = 0;
    chk("t3_nvld",     n_vld, 6);
    chk("t3_fflags",   cap_ff, 5'h06);
    chk("t3_idle",     int'(fdsu_busy), 0);
    repeat (2) tick();
    chk("t3_no_accept", int'(fdsu_busy), 0);

    // Flush at T+6, then start and flush together while idle
    clr_stats(); T = ncyc;
    do_start(0, 0, 8'h11, 4'h2, 5'h00);
    while (ncyc < T + 6) tick();
    fpu_fdsu_flush = 1;
    tick();
    fpu_fdsu_flush = 0;
    chk("t4_busy",  int'(fdsu_busy), 0);
    chk("t4_iter",  int'(srt_iter_en), 0);
    fdsu_ex1_start = 1; ex1_div = 1; fpu_fdsu_flush = 1;
    tick();
    fdsu_ex1_start = 0; ex1_div = 0; fpu_fdsu_flush = 0;
    chk("t4_start_flush", int'(fdsu_busy), 0);
    repeat (20) tick();
    chk("t4_nvld", n_vld, 0);

    // A zero remainder at T+4
    clr_stats(); T = ncyc;
    do_start(0, 0, 8'h22, 4'h4, 5'h00);
    while (ncyc < T + 4) tick();
    srt_rem_zero = 1;
    tick();
    srt_rem_zero = 0;
    run_until_vld(40);
`ifdef PA_FDSU_EARLY_TERM_EN
    chk("t5_vld_lat", vld_first - T, 6);
    chk("t5_rnd_lat", rnd_first - T, 5);
`else
    chk("t5_vld_lat", vld_first - T, 15);
    chk("t5_rnd_lat", rnd_first - T, 14);
`endif
    repeat (2) tick();

    // Asynchronous reset in the middle of an operation
    do_start(0, 1, 8'h33, 4'h5, 5'h01);
    repeat (4) tick();
    #2 cpurst_b = 0;
    #1;
    chk("t6_busy", int'(fdsu_busy), 0);
    chk("t6_iter", int'(srt_iter_en), 0);
    chk("t6_cnt",  int'(srt_cnt), 0);
    chk("t6_sqrt", int'(fdsu_wb_op_sqrt), 0);
    m_active = 0;
    @(negedge clk);
    cpurst_b = 1;
    ncyc++;
    check();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      fdsu_ex1_start    = ($urandom_range(3) == 0);
      ex1_div           = $urandom_range(1);
      ex1_sqrt          = $urandom_range(1);
      ex1_srt_skip      = ($urandom_range(3) == 0);
      sel_in            = 8'($urandom);
      sign_in           = 4'($urandom);
      ff_in             = 5'($urandom);
      rnd_fflags        = 5'($urandom);
      srt_rem_zero      = ($urandom_range(7) == 0);
      fpu_fdsu_flush    = ($urandom_range(31) == 0);
      fpu_fdsu_wb_ready = $urandom_range(1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
